// File: rtl/fifo_arb_pkg.sv
// Shared defaults and sizing helpers for the FIFO write arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    localparam int NREQ_DEF       = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;

    // Credit counter must represent every value 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot winner plus its index, searching
// from the requester after last_gnt and wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]        req,
    input  logic [idx_w(NREQ)-1:0] last_gnt,
    input  logic                   en,
    output logic [NREQ-1:0]        gnt,
    output logic [idx_w(NREQ)-1:0] gnt_idx
);

    localparam int IW = idx_w(NREQ);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_gnt) + k) % NREQ;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Credit-based round-robin arbiter funnelling NREQ write requesters into one
// sync_fifo write port; credits track free FIFO slots including in-flight writes.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*DATA_WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]                 gnt,
    input  logic                            fifo_rd_en,
    input  logic                            fifo_empty,
    input  logic                            fifo_full,
    output logic                            wr_en,
    output logic [DATA_WIDTH-1:0]           din,
    output logic [credit_w(DEPTH)-1:0]      credits,
    output logic                            ovf_err
);

    localparam int              CW           = credit_w(DEPTH);
    localparam int              IW           = idx_w(NREQ);
    localparam logic [CW-1:0]   FULL_CREDITS = CW'(DEPTH);
    localparam logic [IW-1:0]   LAST_RST     = IW'(NREQ - 1);

    logic [CW-1:0]          credits_q, credits_d;
    logic [IW-1:0]          last_gnt_q, last_gnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic                   ovf_err_q, ovf_err_d;

    logic                   pick_en;
    logic [IW-1:0]          gnt_idx;
    logic                   grant;
    logic                   pop;

    // Granting only on registered credits means a pop at zero credits opens
    // the window one cycle later rather than creating a comb path rd_en->gnt.
    assign pick_en = rstn && (credits_q != '0);

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .en       (pick_en),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    assign grant = |(gnt & req);
    // A pop with every slot already free cannot be real; ignore it.
    assign pop   = fifo_rd_en && !fifo_empty && (credits_q != FULL_CREDITS);

    always_comb begin
        credits_d  = credits_q;
        last_gnt_d = last_gnt_q;
        wr_en_d    = grant;
        din_d      = din_q;
        ovf_err_d  = ovf_err_q | (wr_en_q & fifo_full);

        if (grant) begin
            last_gnt_d = gnt_idx;
            din_d      = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end

        if (grant && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (!grant && pop) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            credits_q  <= FULL_CREDITS;
            last_gnt_q <= LAST_RST;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            last_gnt_q <= last_gnt_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign din     = din_q;
    assign credits = credits_q;
    assign ovf_err = ovf_err_q;

endmodule
